// File: rtl/snake_pkg.sv
// Shared tile-type codes and default palette for the snake renderer and map writer.
package snake_pkg;

    typedef enum logic [3:0] {
        T_GROUND    = 4'd0,
        T_FOOD      = 4'd1,
        T_BODY_H    = 4'd2,
        T_BODY_V    = 4'd3,
        T_CORNER_LU = 4'd4,
        T_CORNER_RU = 4'd5,
        T_CORNER_LD = 4'd6,
        T_CORNER_RD = 4'd7,
        T_TAIL_L    = 4'd8,
        T_TAIL_R    = 4'd9,
        T_TAIL_U    = 4'd10,
        T_TAIL_D    = 4'd11,
        T_HEAD_L    = 4'd12,
        T_HEAD_R    = 4'd13,
        T_HEAD_U    = 4'd14,
        T_HEAD_D    = 4'd15
    } tile_type_e;

    localparam logic [11:0] DEF_C_GROUND = 12'h0F0;
    localparam logic [11:0] DEF_C_BODY   = 12'hF00;
    localparam logic [11:0] DEF_C_FOOD   = 12'h0FF;
    localparam logic [11:0] DEF_C_HEAD   = 12'hF0F;
    localparam logic [11:0] DEF_C_BORDER = 12'h000;

endpackage

// File: rtl/tile_texture.sv
// Combinational texture lookup: tile type plus in-tile coordinates (u,v) to a colour.
module tile_texture
    import snake_pkg::*;
#(
    parameter int          TILE_BITS = 5,
    parameter int          TYPE_BITS = 4,
    parameter logic [11:0] C_GROUND  = DEF_C_GROUND,
    parameter logic [11:0] C_BODY    = DEF_C_BODY,
    parameter logic [11:0] C_FOOD    = DEF_C_FOOD,
    parameter logic [11:0] C_HEAD    = DEF_C_HEAD
) (
    input  logic [TYPE_BITS-1:0] i_type,
    input  logic [TILE_BITS-1:0] i_u,
    input  logic [TILE_BITS-1:0] i_v,
    input  logic                 i_phase,
    output logic [11:0]          o_rgb
);

    localparam logic [TILE_BITS-1:0] Q1 = TILE_BITS'((1 << TILE_BITS) / 4);
    localparam logic [TILE_BITS-1:0] Q3 = TILE_BITS'((3 * (1 << TILE_BITS)) / 4);

    logic       w_band_u, w_band_v, w_sq;
    logic       w_half_l, w_half_r, w_half_u, w_half_d;
    logic       w_ext;
    logic [3:0] w_code;
    logic       w_body, w_head, w_food;

    assign w_band_u = (i_u >= Q1) && (i_u < Q3);
    assign w_band_v = (i_v >= Q1) && (i_v < Q3);
    assign w_sq     = w_band_u && w_band_v;
    // Half-bands: the centre stripe extended to one edge of the tile.
    assign w_half_l = w_band_v && (i_u < Q3);
    assign w_half_r = w_band_v && (i_u >= Q1);
    assign w_half_u = w_band_u && (i_v < Q3);
    assign w_half_d = w_band_u && (i_v >= Q1);

    assign w_code = i_type[3:0];
    assign w_ext  = (i_type >> 4) != '0;

    always_comb begin
        w_body = 1'b0;
        w_head = 1'b0;
        w_food = 1'b0;
        case (w_code)
            T_FOOD:      w_food = w_sq && i_phase;
            T_BODY_H:    w_body = w_band_v;
            T_BODY_V:    w_body = w_band_u;
            T_CORNER_LU: w_body = w_half_l || w_half_u;
            T_CORNER_RU: w_body = w_half_r || w_half_u;
            T_CORNER_LD: w_body = w_half_l || w_half_d;
            T_CORNER_RD: w_body = w_half_r || w_half_d;
            T_TAIL_L:    w_body = w_half_l;
            T_TAIL_R:    w_body = w_half_r;
            T_TAIL_U:    w_body = w_half_u;
            T_TAIL_D:    w_body = w_half_d;
            // Heads trail their body toward the side they came from.
            T_HEAD_L:    begin w_head = w_sq; w_body = w_half_r; end
            T_HEAD_R:    begin w_head = w_sq; w_body = w_half_l; end
            T_HEAD_U:    begin w_head = w_sq; w_body = w_half_d; end
            T_HEAD_D:    begin w_head = w_sq; w_body = w_half_u; end
            default:     ;
        endcase
        if (w_ext) begin
            w_body = 1'b0;
            w_head = 1'b0;
            w_food = 1'b0;
        end
    end

    assign o_rgb = w_head ? C_HEAD :
                   w_food ? C_FOOD :
                   w_body ? C_BODY : C_GROUND;

endmodule

// File: rtl/tile_renderer.sv
// Three-stage tile renderer: pixel -> map RAM address -> tile type -> registered colour.
module tile_renderer
    import snake_pkg::*;
#(
    parameter int          TILE_BITS  = 5,
    parameter int          MAP_W_BITS = 4,
    parameter int          MAP_H_BITS = 4,
    parameter int          TYPE_BITS  = 4,
    parameter int          BLINK_BITS = 4,
    parameter logic [11:0] C_GROUND   = DEF_C_GROUND,
    parameter logic [11:0] C_BODY     = DEF_C_BODY,
    parameter logic [11:0] C_FOOD     = DEF_C_FOOD,
    parameter logic [11:0] C_HEAD     = DEF_C_HEAD,
    parameter logic [11:0] C_BORDER   = DEF_C_BORDER
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pix_valid,
    input  logic [9:0]                       pix_x,
    input  logic [9:0]                       pix_y,
    input  logic                             frame_start,
    output logic [MAP_W_BITS+MAP_H_BITS-1:0] map_addr,
    input  logic [TYPE_BITS-1:0]             map_data,
    output logic                             rgb_valid,
    output logic [11:0]                      rgb
);

    localparam int AW = MAP_W_BITS + MAP_H_BITS;

    logic [9:0]           w_tile_x, w_tile_y;
    logic                 w_oob;
    logic [11:0]          w_tex;

    logic [AW-1:0]        r_map_addr;
    logic [TILE_BITS-1:0] r_u1, r_v1, r_u2, r_v2;
    logic                 r_oob1, r_oob2;
    logic                 r_valid1, r_valid2, r_valid3;
    logic [11:0]          r_rgb;
    logic [BLINK_BITS:0]  r_frame_cnt;

    assign w_tile_x = pix_x >> TILE_BITS;
    assign w_tile_y = pix_y >> TILE_BITS;
    assign w_oob    = ((w_tile_x >> MAP_W_BITS) != 10'd0) ||
                      ((w_tile_y >> MAP_H_BITS) != 10'd0);

    // Stage 1 feeds the RAM address; stage 2 carries u/v alongside the RAM's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map_addr <= '0;
            r_u1       <= '0;
            r_v1       <= '0;
            r_oob1     <= 1'b0;
            r_valid1   <= 1'b0;
            r_u2       <= '0;
            r_v2       <= '0;
            r_oob2     <= 1'b0;
            r_valid2   <= 1'b0;
        end else begin
            r_map_addr <= {w_tile_y[MAP_H_BITS-1:0], w_tile_x[MAP_W_BITS-1:0]};
            r_u1       <= pix_x[TILE_BITS-1:0];
            r_v1       <= pix_y[TILE_BITS-1:0];
            r_oob1     <= w_oob;
            r_valid1   <= pix_valid;
            r_u2       <= r_u1;
            r_v2       <= r_v1;
            r_oob2     <= r_oob1;
            r_valid2   <= r_valid1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + {{BLINK_BITS{1'b0}}, 1'b1};
        end
    end

    tile_texture #(
        .TILE_BITS (TILE_BITS),
        .TYPE_BITS (TYPE_BITS),
        .C_GROUND  (C_GROUND),
        .C_BODY    (C_BODY),
        .C_FOOD    (C_FOOD),
        .C_HEAD    (C_HEAD)
    ) u_texture (
        .i_type  (map_data),
        .i_u     (r_u2),
        .i_v     (r_v2),
        .i_phase (~r_frame_cnt[BLINK_BITS]),
        .o_rgb   (w_tex)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb    <= 12'h000;
            r_valid3 <= 1'b0;
        end else begin
            r_valid3 <= r_valid2;
            if (!r_valid2)   r_rgb <= 12'h000;
            else if (r_oob2) r_rgb <= C_BORDER;
            else             r_rgb <= w_tex;
        end
    end

    assign map_addr  = r_map_addr;
    assign rgb_valid = r_valid3;
    assign rgb       = r_rgb;

endmodule
